// File: rtl/receiver_pkg.sv
// Shared definitions for the UART receiver.
//   UART_pkg : FIFO depth, configuration-request threshold, data-width and
//              stop-bit codes, helper to map a width code to its last bit index.
//   fsm_pkg  : receiver state encoding.
package UART_pkg;
    localparam int RX_FIFO_DEPTH = 8;
    // Continuous low time, in clk_i cycles, that is read as a configuration request.
    localparam int COUNT_1MS = 1000;

    localparam logic [1:0] DW_5BIT = 2'd0;
    localparam logic [1:0] DW_6BIT = 2'd1;
    localparam logic [1:0] DW_7BIT = 2'd2;
    localparam logic [1:0] DW_8BIT = 2'd3;

    localparam logic [1:0] SB_1BIT = 2'd0;
    localparam logic [1:0] SB_2BIT = 2'd1;

    // Index of the final data bit for a width code (5 bits -> index 4).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] dw);
        return 3'd4 + {1'b0, dw};
    endfunction
endpackage

package fsm_pkg;
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_CFG_WAIT
    } receiver_fsm_e;
endpackage

// File: rtl/receiver_fifo.sv
// Receive FIFO, first-word-fall-through.
//   sync_fifo_interface : write/read/flush controls, write data, head data, status.
//   sync_FIFO_buffer    : clk_i, rst_n_i (synchronous, active low), bus (fifo modport).
// The head reads as zero while empty. A write while full is dropped unless a
// read happens in the same cycle, in which case both take effect.
interface sync_fifo_interface;
    logic       wr_en;
    logic       rd_en;
    logic       flush;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;

    modport fifo (input wr_en, rd_en, flush, wr_data, output rd_data, empty, full);
    modport user (output wr_en, rd_en, flush, wr_data, input rd_data, empty, full);
endinterface

module sync_FIFO_buffer
    import UART_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    sync_fifo_interface.fifo bus
);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam int CW = $clog2(RX_FIFO_DEPTH + 1);

    logic [7:0]    mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(RX_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.empty   = (count == '0);
    assign bus.full    = (count == CW'(RX_FIFO_DEPTH));
    assign bus.rd_data = bus.empty ? 8'h00 : mem[rd_ptr];
    assign do_rd       = bus.rd_en && !bus.empty;
    assign do_wr       = bus.wr_en && (!bus.full || do_rd);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr] <= bus.wr_data;
    end
endmodule

// File: rtl/receiver.sv
// UART receiver with 16x oversampling, receive FIFO and line-low
// configuration-request detection.
// Ports:
//   clk_i, rst_n_i (synchronous, active low), enable (allows new frames),
//   ov_baud_rt_i (16x baud tick), rx_i (serial line, idle high),
//   rx_fifo_read_i (pop head), data_width_i / stop_bits_number_i /
//   parity_mode_i (frame format), data_rx_o (FIFO head), rx_done_o and
//   frame/parity/overrun error pulses, config_req_slv_o, FIFO empty/full.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a falling edge
// RX_START     | timing to the middle of the start bit
// RX_DATA      | sampling data bits, LSB first
// RX_PARITY    | sampling the parity bit
// RX_STOP      | sampling one or two stop bits, frame ends here
// RX_CFG_WAIT  | configuration request seen, waiting for the line to rise
module receiver
    import UART_pkg::*;
    import fsm_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable,
    input  logic       ov_baud_rt_i,
    input  logic       rx_i,
    input  logic       rx_fifo_read_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] stop_bits_number_i,
    input  logic [1:0] parity_mode_i,
    output logic [7:0] data_rx_o,
    output logic       rx_done_o,
    output logic       frame_error_o,
    output logic       parity_error_o,
    output logic       overrun_error_o,
    output logic       config_req_slv_o,
    output logic       rx_fifo_empty_o,
    output logic       rx_fifo_full_o
);
    localparam int LW = $clog2(COUNT_1MS + 1);

    receiver_fsm_e state, state_next;
    logic          rx_meta, rx_s;
    logic [LW-1:0] low_cnt;
    logic [3:0]    tick_cnt, tick_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    data_reg, data_next;
    logic          second_stop, second_next;
    logic          perr_lat, perr_next;
    logic          ferr_lat, ferr_next;
    logic          frame_end;
    logic          low_hit;
    logic          tick_done;

    sync_fifo_interface fifo_if ();

    sync_FIFO_buffer u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (fifo_if)
    );

    assign fifo_if.wr_en   = frame_end;
    assign fifo_if.rd_en   = rx_fifo_read_i;
    assign fifo_if.flush   = low_hit;
    assign fifo_if.wr_data = data_reg;
    assign data_rx_o       = fifo_if.rd_data;
    assign rx_fifo_empty_o = fifo_if.empty;
    assign rx_fifo_full_o  = fifo_if.full;

    // The low counter saturates at the threshold, so this fires once per low period.
    assign low_hit   = !rx_s && (low_cnt == LW'(COUNT_1MS - 1));
    // Bit timer is a down-counter; the terminal count on a tick is the sample point.
    assign tick_done = ov_baud_rt_i && (tick_cnt == 4'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_meta          <= 1'b1;
            rx_s             <= 1'b1;
            low_cnt          <= '0;
            state            <= RX_IDLE;
            tick_cnt         <= 4'd0;
            bit_idx          <= 3'd0;
            data_reg         <= 8'h00;
            second_stop      <= 1'b0;
            perr_lat         <= 1'b0;
            ferr_lat         <= 1'b0;
            rx_done_o        <= 1'b0;
            frame_error_o    <= 1'b0;
            parity_error_o   <= 1'b0;
            overrun_error_o  <= 1'b0;
            config_req_slv_o <= 1'b0;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            if (rx_s) begin
                low_cnt <= '0;
            end else if (low_cnt != LW'(COUNT_1MS)) begin
                low_cnt <= low_cnt + 1'b1;
            end
            state            <= state_next;
            tick_cnt         <= tick_next;
            bit_idx          <= bit_next;
            data_reg         <= data_next;
            second_stop      <= second_next;
            perr_lat         <= perr_next;
            ferr_lat         <= ferr_next;
            rx_done_o        <= frame_end;
            frame_error_o    <= frame_end && ferr_next;
            parity_error_o   <= frame_end && perr_lat;
            overrun_error_o  <= frame_end && fifo_if.full && !rx_fifo_read_i;
            config_req_slv_o <= low_hit;
        end
    end

    always_comb begin
        state_next  = state;
        tick_next   = tick_cnt;
        bit_next    = bit_idx;
        data_next   = data_reg;
        second_next = second_stop;
        perr_next   = perr_lat;
        ferr_next   = ferr_lat;
        frame_end   = 1'b0;

        case (state)
            RX_IDLE: begin
                if (!rx_s && enable) begin
                    state_next = RX_START;
                    tick_next  = 4'd7;
                end
            end
            RX_START: begin
                if (tick_done) begin
                    if (rx_s) begin
                        state_next = RX_IDLE;
                    end else begin
                        state_next  = RX_DATA;
                        tick_next   = 4'd15;
                        bit_next    = 3'd0;
                        data_next   = 8'h00;
                        second_next = 1'b0;
                        perr_next   = 1'b0;
                        ferr_next   = 1'b0;
                    end
                end else if (ov_baud_rt_i) begin
                    tick_next = tick_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (tick_done) begin
                    data_next[bit_idx] = rx_s;
                    tick_next          = 4'd15;
                    if (bit_idx == last_bit_idx(data_width_i)) begin
                        state_next = parity_mode_i[1] ? RX_STOP : RX_PARITY;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else if (ov_baud_rt_i) begin
                    tick_next = tick_cnt - 1'b1;
                end
            end
            RX_PARITY: begin
                if (tick_done) begin
                    perr_next  = ((^data_reg) ^ rx_s) != parity_mode_i[0];
                    tick_next  = 4'd15;
                    state_next = RX_STOP;
                end else if (ov_baud_rt_i) begin
                    tick_next = tick_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (tick_done) begin
                    ferr_next = ferr_lat || !rx_s;
                    tick_next = 4'd15;
                    if (stop_bits_number_i == SB_2BIT && !second_stop) begin
                        second_next = 1'b1;
                    end else begin
                        frame_end  = 1'b1;
                        state_next = RX_IDLE;
                    end
                end else if (ov_baud_rt_i) begin
                    tick_next = tick_cnt - 1'b1;
                end
            end
            RX_CFG_WAIT: begin
                if (rx_s) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase

        // A configuration request aborts whatever frame is in flight.
        if (low_hit) begin
            state_next = RX_CFG_WAIT;
            frame_end  = 1'b0;
        end
    end
endmodule

// File: tb/tb_receiver.sv
module tb_receiver;
    import UART_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       ov_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [1:0] dw = DW_8BIT;
    logic [1:0] sb = SB_1BIT;
    logic [1:0] pm = 2'b10;
    logic [7:0] data_rx_o;
    logic       rx_done_o, frame_error_o, parity_error_o, overrun_error_o;
    logic       config_req_slv_o, rx_fifo_empty_o, rx_fifo_full_o;

    typedef struct {
        logic perr;
        logic ferr;
        logic ovr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cfg_pulses = 0;
    int         cfg_before;
    bit         tick_en = 1'b1;
    logic [7:0] r_d;
    logic [1:0] r_dw, r_sb, r_pm;
    bit         r_flip, r_bad;

    receiver dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .enable             (enable),
        .ov_baud_rt_i       (ov_tick),
        .rx_i               (rx),
        .rx_fifo_read_i     (rd),
        .data_width_i       (dw),
        .stop_bits_number_i (sb),
        .parity_mode_i      (pm),
        .data_rx_o          (data_rx_o),
        .rx_done_o          (rx_done_o),
        .frame_error_o      (frame_error_o),
        .parity_error_o     (parity_error_o),
        .overrun_error_o    (overrun_error_o),
        .config_req_slv_o   (config_req_slv_o),
        .rx_fifo_empty_o    (rx_fifo_empty_o),
        .rx_fifo_full_o     (rx_fifo_full_o)
    );

    always #5 clk = ~clk;

    // 16x tick every 4 clocks, so one bit lasts 64 clocks.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            ov_tick = tick_en;
            @(negedge clk);
            ov_tick = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got time %0t, required finish before it", $time);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed frame is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (config_req_slv_o) cfg_pulses++;
            if (rx_done_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rx_done", int'(rx_done_o), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("parity_error", int'(parity_error_o), int'(mon_e.perr));
                    check("frame_error", int'(frame_error_o), int'(mon_e.ferr));
                    check("overrun_error", int'(overrun_error_o), int'(mon_e.ovr));
                end
            end else if (frame_error_o || parity_error_o || overrun_error_o) begin
                check("error_without_done", int'({frame_error_o, parity_error_o, overrun_error_o}), 0);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] f_dw, input logic [1:0] f_sb,
                              input logic [1:0] f_pm, input bit flip_par, input bit bad_stop,
                              input bit accept);
        int         nbits;
        int         nstop;
        logic [7:0] dm;
        logic       par;
        exp_t       e;
        nbits = 5 + int'(f_dw);
        nstop = (f_sb == SB_2BIT) ? 2 : 1;
        dm    = d & (8'hFF >> (8 - nbits));
        par   = (^dm) ^ f_pm[0] ^ flip_par;
        dw = f_dw;
        sb = f_sb;
        pm = f_pm;
        if (accept) begin
            e.perr = flip_par && !f_pm[1];
            e.ferr = bad_stop;
            e.ovr  = model_q.size() >= RX_FIFO_DEPTH;
            exp_q.push_back(e);
            if (!e.ovr) model_q.push_back(dm);
        end
        rx = 1'b0;
        wait_clk(64);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            wait_clk(64);
        end
        if (!f_pm[1]) begin
            rx = par;
            wait_clk(64);
        end
        for (int s = 0; s < nstop; s++) begin
            if (bad_stop && s == nstop - 1) begin
                rx = 1'b0;
                wait_clk(40);
                rx = 1'b1;
                wait_clk(24);
            end else begin
                rx = 1'b1;
                wait_clk(64);
            end
        end
        wait_clk(128);
        check("frame_seen", exp_q.size(), 0);
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp_d;
        if (model_q.size() == 0) begin
            check({name, "_empty"}, int'(rx_fifo_empty_o), 1);
        end else begin
            exp_d = model_q.pop_front();
            check({name, "_data"}, int'(data_rx_o), int'(exp_d));
            check({name, "_not_empty"}, int'(rx_fifo_empty_o), 0);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
        end
    endtask

    task automatic drain();
        while (model_q.size() > 0) pop_check("drain");
        check("empty_after_drain", int'(rx_fifo_empty_o), 1);
    endtask

    initial begin
        wait_clk(5);
        check("rst_empty", int'(rx_fifo_empty_o), 1);
        check("rst_full", int'(rx_fifo_full_o), 0);
        check("rst_data", int'(data_rx_o), 0);
        check("rst_pulses", int'({rx_done_o, frame_error_o, parity_error_o, overrun_error_o, config_req_slv_o}), 0);
        rst_n = 1'b1;
        wait_clk(10);

        send_frame(8'hA5, DW_8BIT, SB_1BIT, 2'b10, 1'b0, 1'b0, 1'b1);
        pop_check("8n1_a5");
        send_frame(8'h35, DW_7BIT, SB_2BIT, 2'b00, 1'b0, 1'b0, 1'b1);
        pop_check("7e2_35");
        send_frame(8'h35, DW_7BIT, SB_2BIT, 2'b00, 1'b1, 1'b0, 1'b1);
        pop_check("7e2_35_badpar");
        send_frame(8'h1F, DW_5BIT, SB_1BIT, 2'b01, 1'b0, 1'b1, 1'b1);
        pop_check("5o1_1f_badstop");

        rx = 1'b0;
        wait_clk(16);
        rx = 1'b1;
        wait_clk(200);
        check("glitch_fifo_empty", int'(rx_fifo_empty_o), 1);
        send_frame(8'h3C, DW_8BIT, SB_1BIT, 2'b10, 1'b0, 1'b0, 1'b1);
        pop_check("after_glitch");

        for (int k = 0; k <= RX_FIFO_DEPTH; k++) begin
            r_d = 8'($urandom);
            send_frame(r_d, DW_8BIT, SB_1BIT, 2'b10, 1'b0, 1'b0, 1'b1);
        end
        check("overrun_full", int'(rx_fifo_full_o), 1);
        drain();

        fork
            send_frame(8'h5A, DW_8BIT, SB_1BIT, 2'b10, 1'b0, 1'b0, 1'b1);
            begin
                wait_clk(100);
                enable = 1'b0;
            end
        join
        enable = 1'b1;
        pop_check("enable_drop_midframe");
        enable = 1'b0;
        send_frame(8'hFF, DW_8BIT, SB_1BIT, 2'b10, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        check("disabled_no_write", int'(rx_fifo_empty_o), 1);

        send_frame(8'h11, DW_8BIT, SB_1BIT, 2'b10, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, DW_8BIT, SB_1BIT, 2'b10, 1'b0, 1'b0, 1'b1);
        cfg_before = cfg_pulses;
        rx = 1'b0;
        wait_clk(64);
        rx = 1'b1;
        wait_clk(192);
        tick_en = 1'b0;
        rx = 1'b0;
        wait_clk(COUNT_1MS + 100);
        check("cfg_one_pulse", cfg_pulses - cfg_before, 1);
        check("cfg_fifo_flushed", int'(rx_fifo_empty_o), 1);
        model_q.delete();
        rx = 1'b1;
        wait_clk(100);
        tick_en = 1'b1;
        wait_clk(128);
        send_frame(8'hC3, DW_8BIT, SB_1BIT, 2'b10, 1'b0, 1'b0, 1'b1);
        pop_check("after_cfg");

        for (int k = 0; k < 16; k++) begin
            r_d    = 8'($urandom);
            r_dw   = 2'($urandom_range(0, 3));
            r_sb   = 2'($urandom_range(0, 3));
            r_pm   = 2'($urandom_range(0, 3));
            r_flip = ($urandom_range(0, 3) == 0);
            r_bad  = ($urandom_range(0, 3) == 0);
            send_frame(r_d, r_dw, r_sb, r_pm, r_flip, r_bad, 1'b1);
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(0, model_q.size())) pop_check("rand");
            end
        end
        drain();

        check("cfg_pulse_total", cfg_pulses, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
